otter_icache: RTL
=================

# otter_icache

Direct-mapped, read-only instruction cache for the pipelined OTTER fetch stage. It sits between the PC/fetch stage and the instruction port (port 1) of the OTTER memory, and replaces the memory's direct connection to the pipeline. Hits return an instruction with the same one-cycle registered latency the pipeline already expects from the memory. Misses stall the pipeline while a full line is burst-read through the memory's synchronous instruction port.

## Interface
Parameters:
- `LINES`, 16: number of cache lines; power of 2.
- `WORDS`, 8: 32-bit words per line; power of 2.

Ports:
- `CLK`  in  1  single clock for the whole block.
- `RST`  in  1  synchronous, active-high reset.
- `PC`  in  32  fetch byte address; bits [1:0] ignored.
- `RD_EN`  in  1  fetch request; when low, no lookup occurs and `INSTR` holds.
- `FLUSH`  in  1  invalidate all lines (fence.i); single-cycle pulse.
- `INSTR`  out  32  registered instruction.
- `INSTR_VALID`  out  1  registered; `INSTR` was loaded by a hit on the previous cycle.
- `STALL`  out  1  combinational; while high, the pipeline holds `PC`.
- `MEM_RDEN1`  out  1  memory instruction read enable.
- `MEM_ADDR1`  out  14  memory word address.
- `MEM_DOUT1`  in  32  memory instruction data; valid one cycle after `MEM_RDEN1`.

## Operation
- Address split with defaults: word offset `PC[4:2]`, index `PC[8:5]`, tag `PC[31:9]`. Widths track `$clog2(WORDS)` and `$clog2(LINES)`.
- Storage per line: valid bit, tag, and `WORDS` data words. Use distributed RAM or registers; lookup is combinational.
- Hit condition: `hit = valid[idx] & (tag[idx] == PC tag) & state==IDLE & ~FLUSH`.
- FSM states:
  - IDLE:
    - `RD_EN & hit`: `INSTR <= word`, `INSTR_VALID <= 1`.
    - `RD_EN & ~hit & ~FLUSH`: latch `{tag, idx}` of `PC`, clear `valid[idx]`, reset counters, go to FILL, `INSTR_VALID <= 0`.
    - `RD_EN` low: `INSTR` holds, `INSTR_VALID <= 0`.
  - FILL: issue counter `req` runs 0..`WORDS`-1 and drives `MEM_RDEN1=1`, `MEM_ADDR1 = {latched PC[15:5], req}`. Capture counter `cap` writes `MEM_DOUT1` into word `cap` one cycle after each issue. After the last capture, set the valid bit and store the tag, then go to IDLE. FILL lasts `WORDS`+1 cycles.
- `STALL = (state != IDLE) | (RD_EN & ~hit)`, forced to 0 while `RST`.
- `MEM_RDEN1` is 0 outside FILL issue cycles.
- `PC` changes during FILL are ignored; the fill uses the latched line address.
- FLUSH:
  - Clears all valid bits at the clock edge.
  - In IDLE, the same-cycle lookup is forced to miss and no fill starts that cycle.
  - In FILL, the fill aborts, the next state is IDLE, the in-flight read data is discarded, and the line stays invalid.
- Reset (any state, including mid-fill):
  - state IDLE, all valid bits 0, counters 0.
  - `INSTR = 32'h00000013` (nop), `INSTR_VALID = 0`.
  - `MEM_RDEN1 = 0`, `MEM_ADDR1 = 0`.
  - Data and tag arrays need no reset.

## Timing
- Hit: `PC` is presented in cycle n; `INSTR` and `INSTR_VALID` update at the end of n, the same latency as the memory's instruction port.
- Miss detected in cycle n with `STALL=1`.
- Issues run in cycles n+1..n+`WORDS`; captures run in n+2..n+`WORDS`+1.
- Cycle n+`WORDS`+2 is IDLE and hits; `STALL` stays high for `WORDS`+2 cycles in total (10 with defaults).
- No back-to-back fills without an intervening IDLE lookup cycle.

## Configuration
- `ICACHE_STATS_EN` defined:
  - Adds outputs `HIT_CNT` and `MISS_CNT` (32 bits each, wrapping).
  - `HIT_CNT` increments on each IDLE `RD_EN & hit`; `MISS_CNT` increments on each IDLE to FILL transition.
  - Both reset to 0 on `RST`; `FLUSH` does not clear them.
- `ICACHE_STATS_EN` undefined: the ports and counters do not exist, and all other behaviour is identical.

## Test plan
- Cold miss: after reset, `PC=0x00000000`, `RD_EN=1`:
  - `STALL` is high for 10 cycles.
  - `MEM_ADDR1` steps 0..7 with `MEM_RDEN1=1` for 8 cycles.
  - Then `INSTR = mem[0]` and `INSTR_VALID=1`.
- Sequential hits: `PC` steps 0x04..0x1C after the fill. Required: 7 consecutive cycles with `STALL=0` and `INSTR = mem[1..7]`, each one cycle after its `PC`, with no memory reads.
- Conflict eviction:
  - Fill `PC=0x000`, then fetch `PC=0x200` (same index, new tag): expect a miss and a refill from `MEM_ADDR1` 0x80..0x87.
  - Re-fetch 0x000: expect a miss again.
- FLUSH mid-fill: assert `FLUSH` on fill cycle 4. Required:
  - The next state is IDLE and `MEM_RDEN1` drops.
  - The same `PC` misses and restarts a full 8-word fill.
  - `INSTR` is never updated with partial-line data.
- Reset mid-fill: `RST=1` on fill cycle 3. Required:
  - `INSTR=0x00000013`, `INSTR_VALID=0`, `STALL=0` during the reset cycle.
  - All lines are invalid afterwards.
- `RD_EN` low on a hit address: `INSTR` holds its value, `INSTR_VALID=0`, no counter change (`HIT_CNT` unchanged with `ICACHE_STATS_EN`).

Source files
------------

// File: rtl/otter_icache.sv
// otter_icache -- direct-mapped, read-only instruction cache for the pipelined
// OTTER fetch stage. It sits between the PC/fetch stage and the synchronous
// instruction port (port 1) of the OTTER memory.
//
// A hit returns the instruction one cycle after PC is presented, which is the
// latency the pipeline already expects from the memory. A miss stalls the
// pipeline while the whole line is burst-read from memory.
//
// Optional feature: define ICACHE_STATS_EN to add the HIT_CNT / MISS_CNT
// performance counters. The default build leaves it undefined.
//
// Ports:
//   CLK          single clock
//   RST          synchronous, active-high reset
//   PC           fetch byte address (bits [1:0] ignored)
//   RD_EN        fetch request; when low, no lookup occurs and INSTR holds
//   FLUSH        single-cycle pulse that invalidates every line (fence.i)
//   INSTR        registered instruction
//   INSTR_VALID  registered; INSTR was loaded by a hit on the previous cycle
//   STALL        combinational; the pipeline holds PC while this is high
//   MEM_RDEN1    memory instruction read enable
//   MEM_ADDR1    memory word address
//   MEM_DOUT1    memory instruction data, valid one cycle after MEM_RDEN1
//   HIT_CNT      (ICACHE_STATS_EN only) count of IDLE hits, wrapping
//   MISS_CNT     (ICACHE_STATS_EN only) count of fills started, wrapping
module otter_icache #(
    parameter int LINES = 16,
    parameter int WORDS = 8
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] PC,
    input  logic        RD_EN,
    input  logic        FLUSH,
    output logic [31:0] INSTR,
    output logic        INSTR_VALID,
    output logic        STALL,
    output logic        MEM_RDEN1,
    output logic [13:0] MEM_ADDR1,
    input  logic [31:0] MEM_DOUT1
`ifdef ICACHE_STATS_EN
    ,
    output logic [31:0] HIT_CNT,
    output logic [31:0] MISS_CNT
`endif
);

    localparam int OFF_W  = $clog2(WORDS);
    localparam int IDX_W  = $clog2(LINES);
    localparam int LINE_W = 30 - OFF_W;      // PC[31:OFF_W+2] = {tag, idx}
    localparam int TAG_W  = LINE_W - IDX_W;
    localparam logic [OFF_W-1:0] LAST = OFF_W'(WORDS - 1);

    typedef enum logic {IDLE = 1'b0, FILL = 1'b1} state_t;

    state_t            state;
    logic [LINES-1:0]  valid;
    logic [TAG_W-1:0]  tags [LINES];
    logic [31:0]       data_mem [LINES*WORDS];

    logic [LINE_W-1:0] fill_line;
    logic [OFF_W-1:0]  req;
    logic [OFF_W-1:0]  cap;
    logic              cap_en;

    logic [LINE_W-1:0] pc_line;
    logic [OFF_W-1:0]  pc_word;
    logic [IDX_W-1:0]  pc_idx;
    logic [TAG_W-1:0]  pc_tag;
    logic [IDX_W-1:0]  fill_idx;
    logic [TAG_W-1:0]  fill_tag;
    logic              hit;
    logic              start_fill;
    logic              last_cap;
    logic              unused_pc_bits;

    assign pc_line  = PC[31:OFF_W+2];
    assign pc_word  = PC[OFF_W+1:2];
    assign pc_idx   = pc_line[IDX_W-1:0];
    assign pc_tag   = pc_line[LINE_W-1:IDX_W];
    assign fill_idx = fill_line[IDX_W-1:0];
    assign fill_tag = fill_line[LINE_W-1:IDX_W];
    assign unused_pc_bits = ^PC[1:0];

    assign hit        = valid[pc_idx] & (tags[pc_idx] == pc_tag) & (state == IDLE) & ~FLUSH;
    assign start_fill = (state == IDLE) & RD_EN & ~hit & ~FLUSH;
    assign last_cap   = (state == FILL) & cap_en & (cap == LAST) & ~FLUSH;

    // Held low during reset so the pipeline is not frozen by a stale miss.
    assign STALL = ~RST & ((state != IDLE) | (RD_EN & ~hit));

    // Memory word address of a word within a line: the line address supplies
    // the upper bits, the word offset the lower ones.
    function automatic logic [13:0] line_word_addr(input logic [LINE_W-1:0] line,
                                                   input logic [OFF_W-1:0]  word);
        return {line[13-OFF_W:0], word};
    endfunction

    // Control FSM and registered outputs. The issue counter req drives the
    // memory address; cap_en marks the cycle after each issue, when the read
    // data is present on MEM_DOUT1 and gets written at word cap.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state       <= IDLE;
            valid       <= '0;
            req         <= '0;
            cap         <= '0;
            cap_en      <= 1'b0;
            INSTR       <= 32'h0000_0013;
            INSTR_VALID <= 1'b0;
            MEM_RDEN1   <= 1'b0;
            MEM_ADDR1   <= '0;
`ifdef ICACHE_STATS_EN
            HIT_CNT     <= '0;
            MISS_CNT    <= '0;
`endif
        end else begin
            if (FLUSH) valid <= '0;
            case (state)
                IDLE: begin
                    cap_en <= 1'b0;
                    if (RD_EN && hit) begin
                        INSTR       <= data_mem[{pc_idx, pc_word}];
                        INSTR_VALID <= 1'b1;
`ifdef ICACHE_STATS_EN
                        HIT_CNT     <= HIT_CNT + 32'd1;
`endif
                    end else if (start_fill) begin
                        state          <= FILL;
                        valid[pc_idx]  <= 1'b0;
                        req            <= '0;
                        cap            <= '0;
                        MEM_RDEN1      <= 1'b1;
                        MEM_ADDR1      <= line_word_addr(pc_line, '0);
                        INSTR_VALID    <= 1'b0;
`ifdef ICACHE_STATS_EN
                        MISS_CNT       <= MISS_CNT + 32'd1;
`endif
                    end else begin
                        INSTR_VALID <= 1'b0;
                    end
                end
                FILL: begin
                    INSTR_VALID <= 1'b0;
                    if (FLUSH) begin
                        // Abort: the read in flight is simply never captured.
                        state     <= IDLE;
                        MEM_RDEN1 <= 1'b0;
                        MEM_ADDR1 <= '0;
                        cap_en    <= 1'b0;
                    end else begin
                        cap_en <= MEM_RDEN1;
                        if (MEM_RDEN1) begin
                            if (req == LAST) begin
                                MEM_RDEN1 <= 1'b0;
                                MEM_ADDR1 <= '0;
                            end else begin
                                req       <= req + 1'b1;
                                MEM_ADDR1 <= line_word_addr(fill_line, req + 1'b1);
                            end
                        end
                        if (cap_en) begin
                            cap <= cap + 1'b1;
                            if (cap == LAST) begin
                                valid[fill_idx] <= 1'b1;
                                state           <= IDLE;
                            end
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Line address latch, data and tag arrays; none of these need a reset
    // because the valid bits guard them.
    always_ff @(posedge CLK) begin
        if (start_fill) fill_line <= pc_line;
        if ((state == FILL) && cap_en && !FLUSH) data_mem[{fill_idx, cap}] <= MEM_DOUT1;
        if (last_cap) tags[fill_idx] <= fill_tag;
    end

endmodule
